// File: rtl/nts_rx_frame_ring.sv
// nts_rx_frame_ring: ring of frame buffers between a 64-bit MAC receive stream and a frame reader.
// Frames are committed whole; bad, oversize or no-room frames are abandoned and counted.
module nts_rx_frame_ring #(
    parameter int ADDR_WIDTH = 8,
    parameter int BUF_BITS   = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [7:0]            i_rx_data_valid,
    input  logic [63:0]           i_rx_data,
    input  logic                  i_rx_good_frame,
    input  logic                  i_rx_bad_frame,
    output logic                  o_packet_available,
    output logic [ADDR_WIDTH-1:0] o_counter,
    output logic [7:0]            o_data_valid,
    input  logic                  i_rd_start,
    input  logic                  i_discard,
    output logic                  o_rd_valid,
    output logic [63:0]           o_rd_data,
    output logic                  o_fifo_empty,
    output logic [CNT_WIDTH-1:0]  o_frames_dropped,
    output logic [CNT_WIDTH-1:0]  o_frames_bad
);
    localparam int NUM_BUF = 1 << BUF_BITS;
    localparam logic [BUF_BITS:0] FULL = (BUF_BITS + 1)'(NUM_BUF);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_WAIT, R_PRIME, R_STREAM, R_DONE} rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;
    logic [BUF_BITS-1:0] wr_idx, rd_idx;
    logic [BUF_BITS:0] fill;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_pos, rd_pos_next, rd_off;
    logic [ADDR_WIDTH-1:0] cnt_mem [NUM_BUF];
    logic [7:0] mask_mem [NUM_BUF];
    logic [63:0] mem [NUM_BUF << ADDR_WIDTH];
    logic we, commit, drop_inc, bad_inc, rd_en, discard, accept, room, frame_end;

    assign frame_end = i_rx_good_frame | i_rx_bad_frame;
    assign discard = i_discard && fill != '0;
    assign o_counter = cnt_mem[rd_idx];
    assign o_data_valid = mask_mem[rd_idx];
    assign o_packet_available = fill != '0 && r_state == R_WAIT;
    assign o_rd_valid = r_state == R_STREAM;
    assign o_fifo_empty = r_state == R_WAIT || r_state == R_DONE;

    // A frame starts only on a full word; room means a free buffer at start, a free address mid-frame
    assign accept = w_state == W_IDLE ? i_rx_data_valid == 8'hff
                                      : w_state == W_RECV && i_rx_data_valid != '0;
    assign room = w_state == W_IDLE ? fill != FULL : wr_addr != LAST_ADDR;

    always_comb begin
        w_next = w_state;
        we = 1'b0;
        wr_off = '0;
        commit = 1'b0;
        drop_inc = 1'b0;
        bad_inc = 1'b0;
        if (accept && room) begin
            we = 1'b1;
            wr_off = w_state == W_IDLE ? '0 : wr_addr + 1'b1;
            commit = i_rx_good_frame;
            bad_inc = i_rx_bad_frame;
            w_next = frame_end ? W_IDLE : W_RECV;
        end else if (accept) begin
            drop_inc = frame_end;
            bad_inc = i_rx_bad_frame;
            w_next = frame_end ? W_IDLE : W_DROP;
        end else if (w_state == W_DROP && frame_end) begin
            drop_inc = 1'b1;
            bad_inc = i_rx_bad_frame;
            w_next = W_IDLE;
        end
    end

    always_comb begin
        r_next = r_state;
        rd_en = 1'b0;
        rd_off = '0;
        rd_pos_next = rd_pos;
        case (r_state)
            R_WAIT: r_next = i_rd_start && fill != '0 ? R_PRIME : R_WAIT;
            R_PRIME: begin
                rd_en = 1'b1;
                rd_pos_next = '0;
                r_next = R_STREAM;
            end
            R_STREAM: begin
                rd_en = rd_pos != o_counter;
                rd_off = rd_pos + 1'b1;
                rd_pos_next = rd_en ? rd_off : rd_pos;
                r_next = rd_en ? R_STREAM : R_DONE;
            end
            default: ;
        endcase
        if (discard) begin
            r_next = R_WAIT;
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            w_state <= W_IDLE;
            r_state <= R_WAIT;
            wr_idx <= '0;
            rd_idx <= '0;
            fill <= '0;
            wr_addr <= '0;
            rd_pos <= '0;
            o_frames_dropped <= '0;
            o_frames_bad <= '0;
            for (int i = 0; i < NUM_BUF; i++) begin
                cnt_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            rd_pos <= rd_pos_next;
            if (we) wr_addr <= wr_off;
            if (commit) begin
                cnt_mem[wr_idx] <= wr_off;
                mask_mem[wr_idx] <= i_rx_data_valid;
                wr_idx <= wr_idx + 1'b1;
            end
            if (discard) rd_idx <= rd_idx + 1'b1;
            fill <= fill + {{BUF_BITS{1'b0}}, commit} - {{BUF_BITS{1'b0}}, discard};
            if (drop_inc && !(&o_frames_dropped)) o_frames_dropped <= o_frames_dropped + 1'b1;
            if (bad_inc && !(&o_frames_bad)) o_frames_bad <= o_frames_bad + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) mem[{wr_idx, wr_off}] <= i_rx_data;
    end

    // Read port register doubles as the held output word
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) o_rd_data <= '0;
        else if (rd_en) o_rd_data <= mem[{rd_idx, rd_off}];
    end
endmodule

// File: tb/tb_nts_rx_frame_ring.sv
// tb_nts_rx_frame_ring: table-driven, directed and randomized checks of the receive frame ring
// against a queue-based model of committed frames.
module tb_nts_rx_frame_ring;
    localparam int AW = 4;
    localparam int NB = 4;
    localparam int DEPTH = 16;
    localparam int OP_NONE = 0, OP_FRAME = 1, OP_READ = 2, OP_DISC = 3;

    logic clk = 1'b0;
    logic areset = 1'b0;
    logic [7:0] rx_valid = '0;
    logic [63:0] rx_data = '0;
    logic rx_good = 1'b0, rx_bad = 1'b0, rd_start = 1'b0, discard = 1'b0;
    logic pkt_avail, rd_valid, fifo_empty;
    logic [AW-1:0] counter;
    logic [7:0] dvalid;
    logic [63:0] rd_data;
    logic [31:0] dropped, bad;

    always #5 clk = ~clk;

    nts_rx_frame_ring #(.ADDR_WIDTH(AW), .BUF_BITS(2), .CNT_WIDTH(32)) dut (
        .i_clk(clk), .i_areset(areset), .i_rx_data_valid(rx_valid), .i_rx_data(rx_data),
        .i_rx_good_frame(rx_good), .i_rx_bad_frame(rx_bad), .o_packet_available(pkt_avail),
        .o_counter(counter), .o_data_valid(dvalid), .i_rd_start(rd_start), .i_discard(discard),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_fifo_empty(fifo_empty),
        .o_frames_dropped(dropped), .o_frames_bad(bad)
    );

    int checks = 0;
    int failures = 0;

    // Model: committed frames as a flat word queue plus per-frame length and last mask
    logic [63:0] m_words[$];
    int m_len[$];
    logic [7:0] m_mask[$];
    int m_dropped = 0;
    int m_bad = 0;
    bit m_reading = 0;

    typedef struct {
        int op;
        int n;
        logic [7:0] mask;
        bit is_bad;
        bit exp_avail;
        int exp_cnt;
        logic [7:0] exp_dv;
        int exp_drop;
        int exp_bad;
    } vec_t;
    vec_t tv[21];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(int n, logic [7:0] mask, bit is_bad, logic [31:0] tag);
        for (int i = 0; i < n; i++) begin
            rx_data = {tag, 32'(i)};
            rx_valid = i == n - 1 ? mask : 8'hff;
            rx_good = i == n - 1 && !is_bad;
            rx_bad = i == n - 1 && is_bad;
            tick();
        end
        rx_valid = '0;
        rx_good = 1'b0;
        rx_bad = 1'b0;
        if (m_len.size() == NB || n > DEPTH) begin
            m_dropped++;
            if (is_bad) m_bad++;
        end else if (is_bad) begin
            m_bad++;
        end else begin
            for (int i = 0; i < n; i++) m_words.push_back({tag, 32'(i)});
            m_len.push_back(n);
            m_mask.push_back(mask);
        end
    endtask

    task automatic do_read;
        int n = m_len[0];
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        @(negedge clk);
        chk("prime_valid", rd_valid, 0);
        chk("prime_empty", fifo_empty, 0);
        chk("prime_avail", pkt_avail, 0);
        for (int k = 0; k < n; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("rd_valid_w%0d", k), rd_valid, 1);
            chk($sformatf("rd_data_w%0d", k), rd_data, m_words[k]);
        end
        tick();
        @(negedge clk);
        chk("done_valid", rd_valid, 0);
        chk("done_empty", fifo_empty, 1);
        chk("done_hold", rd_data, m_words[n-1]);
        m_reading = 1;
    endtask

    task automatic model_pop;
        int n;
        if (m_len.size() != 0) begin
            n = m_len.pop_front();
            void'(m_mask.pop_front());
            for (int i = 0; i < n; i++) void'(m_words.pop_front());
            m_reading = 0;
        end
    endtask

    task automatic do_discard;
        discard = 1'b1;
        tick();
        discard = 1'b0;
        model_pop();
    endtask

    task automatic check_model;
        @(negedge clk);
        chk("m_avail", pkt_avail, m_len.size() != 0 && !m_reading);
        if (m_len.size() != 0) begin
            chk("m_counter", counter, 64'(m_len[0] - 1));
            chk("m_dvalid", dvalid, m_mask[0]);
        end
        chk("m_dropped", dropped, 64'(m_dropped));
        chk("m_bad", bad, 64'(m_bad));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, n;
        bit b;
        logic [7:0] mk;
        tv[0]  = '{OP_NONE,   0, 8'h00, 0, 0,  0, 8'h00, 0, 0};
        tv[1]  = '{OP_FRAME,  3, 8'h0f, 0, 1,  2, 8'h0f, 0, 0};
        tv[2]  = '{OP_READ,   0, 8'h00, 0, 0,  2, 8'h0f, 0, 0};
        tv[3]  = '{OP_DISC,   0, 8'h00, 0, 0, -1, 8'h00, 0, 0};
        tv[4]  = '{OP_FRAME,  5, 8'hff, 1, 0, -1, 8'h00, 0, 1};
        tv[5]  = '{OP_FRAME,  2, 8'h01, 0, 1,  1, 8'h01, 0, 1};
        tv[6]  = '{OP_FRAME,  4, 8'h80, 0, 1,  1, 8'h01, 0, 1};
        tv[7]  = '{OP_FRAME,  1, 8'hff, 0, 1,  1, 8'h01, 0, 1};
        tv[8]  = '{OP_FRAME,  3, 8'h3f, 0, 1,  1, 8'h01, 0, 1};
        tv[9]  = '{OP_FRAME,  2, 8'hff, 0, 1,  1, 8'h01, 1, 1};
        tv[10] = '{OP_DISC,   0, 8'h00, 0, 1,  3, 8'h80, 1, 1};
        tv[11] = '{OP_FRAME,  6, 8'h07, 0, 1,  3, 8'h80, 1, 1};
        tv[12] = '{OP_READ,   0, 8'h00, 0, 0,  3, 8'h80, 1, 1};
        tv[13] = '{OP_DISC,   0, 8'h00, 0, 1,  0, 8'hff, 1, 1};
        tv[14] = '{OP_DISC,   0, 8'h00, 0, 1,  2, 8'h3f, 1, 1};
        tv[15] = '{OP_DISC,   0, 8'h00, 0, 1,  5, 8'h07, 1, 1};
        tv[16] = '{OP_DISC,   0, 8'h00, 0, 0, -1, 8'h00, 1, 1};
        tv[17] = '{OP_FRAME, 17, 8'hff, 0, 0, -1, 8'h00, 2, 1};
        tv[18] = '{OP_FRAME, 16, 8'hff, 0, 1, 15, 8'hff, 2, 1};
        tv[19] = '{OP_READ,   0, 8'h00, 0, 0, 15, 8'hff, 2, 1};
        tv[20] = '{OP_DISC,   0, 8'h00, 0, 0, -1, 8'h00, 2, 1};

        #1 areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_rd_data", rd_data, 0);

        for (int i = 0; i < 21; i++) begin
            case (tv[i].op)
                OP_FRAME: send_frame(tv[i].n, tv[i].mask, tv[i].is_bad, 32'(i));
                OP_READ: do_read();
                OP_DISC: do_discard();
                default: ;
            endcase
            @(negedge clk);
            chk($sformatf("t%0d_avail", i), pkt_avail, tv[i].exp_avail);
            if (tv[i].exp_cnt >= 0) begin
                chk($sformatf("t%0d_counter", i), counter, 64'(tv[i].exp_cnt));
                chk($sformatf("t%0d_dvalid", i), dvalid, tv[i].exp_dv);
            end
            chk($sformatf("t%0d_dropped", i), dropped, 64'(tv[i].exp_drop));
            chk($sformatf("t%0d_bad", i), bad, 64'(tv[i].exp_bad));
        end

        // Discard of a frame under readout lands on the same edge as the next frame's commit
        send_frame(4, 8'h03, 0, 32'h0000_00aa);
        rd_start = 1'b1;
        rx_valid = 8'hff;
        rx_data = {32'h0000_00bb, 32'd0};
        tick();
        rd_start = 1'b0;
        rx_data = {32'h0000_00bb, 32'd1};
        tick();
        rx_data = {32'h0000_00bb, 32'd2};
        rx_valid = 8'h1f;
        rx_good = 1'b1;
        discard = 1'b1;
        @(negedge clk);
        chk("c40_valid_before", rd_valid, 1);
        chk("c40_data_before", rd_data, {32'h0000_00aa, 32'd0});
        tick();
        rx_valid = '0;
        rx_good = 1'b0;
        discard = 1'b0;
        model_pop();
        for (int i = 0; i < 3; i++) m_words.push_back({32'h0000_00bb, 32'(i)});
        m_len.push_back(3);
        m_mask.push_back(8'h1f);
        @(negedge clk);
        chk("c40_valid_after", rd_valid, 0);
        chk("c40_empty_after", fifo_empty, 1);
        chk("c40_avail", pkt_avail, 1);
        chk("c40_counter", counter, 2);
        chk("c40_dvalid", dvalid, 8'h1f);
        do_read();
        do_discard();
        check_model();

        // Reset in the middle of a readout
        send_frame(5, 8'hff, 0, 32'h0000_00cc);
        send_frame(3, 8'h0f, 1, 32'h0000_00cd);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("c41_mid_valid", rd_valid, 1);
        chk("c41_mid_data", rd_data, {32'h0000_00cc, 32'd1});
        #1 areset = 1'b1;
        #1;
        chk("c41_rst_valid", rd_valid, 0);
        chk("c41_rst_empty", fifo_empty, 1);
        chk("c41_rst_avail", pkt_avail, 0);
        tick();
        areset = 1'b0;
        m_words.delete();
        m_len.delete();
        m_mask.delete();
        m_dropped = 0;
        m_bad = 0;
        m_reading = 0;
        tick();
        tick();
        @(negedge clk);
        chk("c41_post_valid", rd_valid, 0);
        chk("c41_post_avail", pkt_avail, 0);
        chk("c41_post_counter", counter, 0);
        chk("c41_post_dvalid", dvalid, 0);
        chk("c41_post_bad", bad, 0);

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                n = $urandom_range(2, 18);
                b = $urandom_range(0, 5) == 0;
                mk = 8'hff >> $urandom_range(0, 7);
                send_frame(n, mk, b, $urandom);
            end else if (op < 8) begin
                if (m_len.size() != 0 && !m_reading) begin
                    do_read();
                end else begin
                    rd_start = 1'b1;
                    tick();
                    rd_start = 1'b0;
                    @(negedge clk);
                    chk("ignored_start_empty", fifo_empty, 1);
                    chk("ignored_start_valid", rd_valid, 0);
                end
            end else begin
                do_discard();
            end
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nts_rx_frame_ring.md
NTS_RX_FRAME_RING -- requirements
Module: nts_rx_frame_ring

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: word-address width of each frame buffer; buffer depth is 2^ADDR_WIDTH 64-bit words.
REQ-002 Parameter BUF_BITS, default 2: log2 of the buffer count; NUM_BUF = 2^BUF_BITS; legal range 1..4.
REQ-003 Parameter CNT_WIDTH, default 32: width of the statistics counters.
REQ-004 i_clk  in  1  clock.
REQ-005 i_areset  in  1  reset, asynchronous, active-high.
REQ-006 i_rx_data_valid  in  8  MAC byte-valid mask; 8'hff on full words, partial mask on last word.
REQ-007 i_rx_data  in  64  MAC data word.
REQ-008 i_rx_good_frame  in  1  frame-end pulse, good; coincides with the last data word.
REQ-009 i_rx_bad_frame  in  1  frame-end pulse, bad; coincides with the last data word.
REQ-010 o_packet_available  out  1  head buffer holds a committed frame and no readout is active.
REQ-011 o_counter  out  ADDR_WIDTH  index of the last word of the head frame.
REQ-012 o_data_valid  out  8  byte mask of the last word of the head frame.
REQ-013 i_rd_start  in  1  pulse; starts readout of the head frame.
REQ-014 i_discard  in  1  pulse; frees the head buffer.
REQ-015 o_rd_valid  out  1  qualifies o_rd_data.
REQ-016 o_rd_data  out  64  readout word.
REQ-017 o_fifo_empty  out  1  high when no readout is in progress.
REQ-018 o_frames_dropped  out  CNT_WIDTH  count of frames dropped for no free buffer or overrun.
REQ-019 o_frames_bad  out  CNT_WIDTH  count of i_rx_bad_frame events.

Function
REQ-020 Buffers SHALL form a circular queue with a write index (wr_idx), a head index (rd_idx) and a fill count (0..NUM_BUF); storage SHALL be one simple dual-port RAM of NUM_BUF*2^ADDR_WIDTH words with 1-cycle read latency.
REQ-021 Write FSM states: IDLE, RECV, DROP.
- IDLE -> RECV on i_rx_data_valid==8'hff with fill<NUM_BUF; word written at address 0.
- IDLE -> DROP on i_rx_data_valid==8'hff with fill==NUM_BUF.
REQ-022 In IDLE, a non-zero mask other than 8'hff, or a frame-end pulse, SHALL be ignored, except that a single-word frame (mask==8'hff with i_rx_good_frame) SHALL commit immediately with counter 0.
REQ-023 In RECV, each non-zero-mask word SHALL be written at the next address; the word with i_rx_good_frame SHALL commit the buffer: record counter and o_data_valid mask, advance wr_idx modulo NUM_BUF, increment fill, return to IDLE.
REQ-024 In RECV, i_rx_bad_frame SHALL abandon the buffer, leave fill and wr_idx unchanged, increment o_frames_bad, and return to IDLE.
REQ-025 In RECV, a word arriving when the address is already 2^ADDR_WIDTH-1 SHALL move the FSM to DROP without writing; the partial frame SHALL be abandoned.
REQ-026 DROP SHALL discard words until a frame-end pulse, then return to IDLE.
REQ-027 o_frames_dropped SHALL increment once per dropped frame, on that frame's end pulse; o_frames_bad SHALL increment on a bad end in DROP as well. Both counters SHALL saturate at all-ones.
REQ-028 Read FSM states: WAIT, PRIME, STREAM, DONE.
- o_packet_available = (fill!=0) && state==WAIT.
- i_rd_start while available -> PRIME; i_rd_start otherwise SHALL be ignored.
REQ-029 Readout SHALL assert o_rd_valid for exactly o_counter+1 consecutive cycles, words in address order, the first valid word 2 cycles after i_rd_start. The FSM SHALL then enter DONE with o_rd_valid low and o_rd_data held.
REQ-030 o_fifo_empty SHALL go low the cycle after i_rd_start is accepted and high again the cycle after the last valid word.
REQ-031 i_discard SHALL, in any read state with fill!=0, abort the readout, deassert o_rd_valid next cycle, advance rd_idx, decrement fill, and return to WAIT; i_discard with fill==0 SHALL be ignored.
REQ-032 A commit and a discard in the same cycle SHALL leave fill unchanged and update both indices.
REQ-033 The buffer being read SHALL never be written: the write side only selects buffers not counted in fill.

Reset
REQ-034 On i_areset: both FSMs idle (IDLE/WAIT), indices and fill 0, counters 0, o_rd_valid 0, o_rd_data 0, o_fifo_empty 1, o_packet_available 0, o_counter 0, o_data_valid 0.
REQ-035 A reset during reception or readout SHALL discard all buffered frames, with no further writes or o_rd_valid after reset assertion.

Verification
REQ-036 3-word good frame, last mask 8'h0f -> o_packet_available=1, o_counter=2, o_data_valid=8'h0f; i_rd_start -> 3 valid words in order, starting 2 cycles later.
REQ-037 NUM_BUF=4: 5 back-to-back good frames with no reads -> 4 committed, o_frames_dropped=1; discard, then a 6th frame -> committed.
REQ-038 Frame ending with i_rx_bad_frame -> o_frames_bad=1, o_packet_available stays 0.
REQ-039 ADDR_WIDTH=4, 17-word frame -> dropped, o_frames_dropped=1; the following 16-word frame commits with o_counter=15.
REQ-040 i_discard mid-readout while a commit occurs in the same cycle -> o_rd_valid low next cycle, fill unchanged, the next frame becomes available.
REQ-041 i_areset mid-readout -> o_rd_valid=0, o_fifo_empty=1, o_packet_available=0.
